// File: rtl/restoring_divider_pkg.sv
// Shared arithmetic package for the restoring divider: FSM state encoding
// and the default operand width.
package restoring_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage : restoring_divider_pkg

// File: rtl/restoring_divider_cla_subtractor.sv
// Carry-lookahead subtractor: diff_c = a - b computed as a + ~b + 1.
// Ports:
//   a, b      : WIDTH-bit unsigned operands
//   diff_c    : WIDTH-bit difference (combinational)
//   borrow_c  : 1 when a < b, i.e. NOT carry-out (combinational)
module cla_subtractor #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff_c,
    output logic             borrow_c
);

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign b_inv = ~b;
    assign gen   = a & b_inv;
    assign prop  = a ^ b_inv;

    // Flattened lookahead: each carry is the OR of every generate term
    // propagated through the bits above it, plus the injected +1 carry-in.
    always_comb begin
        logic acc;
        logic prod;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            acc  = gen[i];
            prod = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & gen[j]);
                prod = prod & prop[j];
            end
            carry[i+1] = acc | (prod & carry[0]);
        end
    end

    assign diff_c   = prop ^ carry[WIDTH-1:0];
    assign borrow_c = ~carry[WIDTH];

endmodule : cla_subtractor

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a division (honoured in IDLE or DONE only)
//   dividend, divisor   : unsigned operands, captured on accepted start
//   busy                : high while iterating
//   done                : one-cycle pulse when results are valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : set with the result when the divisor was zero
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned REM_W = WIDTH + 1;

    div_state_e        state_q, state_d;
    logic [WIDTH-1:0]  dq_q, dq_d;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [REM_W-1:0]  rem_q, rem_d;        // partial remainder
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              dbz_q, dbz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [REM_W-1:0]  shifted_rem;
    logic [REM_W-1:0]  trial_c;
    logic              borrow_c;
    logic [REM_W-1:0]  next_rem;
    logic [WIDTH-1:0]  next_dq;
    logic              unused_rem_msb;

    // Shift {partial remainder, dividend} left by one bit. The partial
    // remainder is always below the divisor, so its MSB never carries data.
    assign shifted_rem = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};

    cla_subtractor #(
        .WIDTH (REM_W)
    ) u_sub (
        .a        (shifted_rem),
        .b        ({1'b0, divisor_q}),
        .diff_c   (trial_c),
        .borrow_c (borrow_c)
    );

    // Keep the trial difference on no-borrow, otherwise restore.
    assign next_rem       = borrow_c ? shifted_rem : trial_c;
    assign next_dq        = {dq_q[WIDTH-2:0], ~borrow_c};
    assign unused_rem_msb = rem_q[WIDTH] ^ next_rem[WIDTH];

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        dq_d        = dq_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    dq_d      = dividend;
                    divisor_d = divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        // Divide-by-zero short-circuits straight to DONE.
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_d = next_rem;
                dq_d  = next_dq;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = ST_DONE;
                    quotient_d  = next_dq;
                    remainder_d = next_rem[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dq_q        <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_q        <= dq_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider at WIDTH = 8.
module tb_restoring_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; counts busy cycles and watches that the held
    // results do not move before done.
    task automatic wait_done(input logic [W-1:0] hq, input logic [W-1:0] hr,
                             output int n, output int nbusy, output bit stable);
        n      = 0;
        nbusy  = 0;
        stable = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nbusy++;
            if (quotient !== hq || remainder !== hr) stable = 1'b0;
            tick();
            n++;
        end
    endtask

    // Issue one division and check latency, busy count and results.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_n, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz);
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        int           n;
        int           nbusy;
        bit           stable;
        hq       = quotient;
        hr       = remainder;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(hq, hr, n, nbusy, stable);
        check({tag, " latency"}, n, exp_n);
        check({tag, " busy_cycles"}, nbusy, exp_n);
        check({tag, " held_before_done"}, 32'(stable), 32'd1);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, div_by_zero, edz);
    endtask

    // One cycle with start low: done must fall, results must hold.
    task automatic go_idle(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er);
        start = 1'b0;
        tick();
        check({tag, " done_pulse_end"}, done, 1'b0);
        check({tag, " busy_idle"}, busy, 1'b0);
        check({tag, " q_held"}, quotient, eq);
        check({tag, " r_held"}, remainder, er);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    initial begin
        vec_t vecs[10];
        int   n;
        int   nbusy;
        bit   stable;
        bit   no_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 8'd0);
        check("reset remainder", remainder, 8'd0);
        check("reset div_by_zero", div_by_zero, 1'b0);
        rst = 1'b0;
        tick();

        do_op("200/7", 8'd200, 8'd7, 8, 8'd28, 8'd4, 1'b0);
        go_idle("200/7", 8'd28, 8'd4);

        // Second operation is started while the first sits in DONE.
        do_op("255/1", 8'd255, 8'd1, 8, 8'd255, 8'd0, 1'b0);
        do_op("5/9 b2b", 8'd5, 8'd9, 8, 8'd0, 8'd5, 1'b0);
        go_idle("5/9", 8'd0, 8'd5);

        do_op("100/0", 8'd100, 8'd0, 0, 8'd255, 8'd100, 1'b1);
        go_idle("100/0", 8'd255, 8'd100);

        // start pulsed mid-RUN must be ignored.
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        dividend = 8'd10;
        divisor  = 8'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(8'd255, 8'd100, n, nbusy, stable);
        check("ignored_start latency", n, 5);
        check("ignored_start held", 32'(stable), 32'd1);
        check("ignored_start quotient", quotient, 8'd28);
        check("ignored_start remainder", remainder, 8'd4);
        check("ignored_start div_by_zero", div_by_zero, 1'b0);
        go_idle("ignored_start", 8'd28, 8'd4);

        // Reset mid-RUN, asserted together with start.
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (3) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst quotient", quotient, 8'd0);
        check("midrst remainder", remainder, 8'd0);
        check("midrst div_by_zero", div_by_zero, 1'b0);
        rst     = 1'b0;
        start   = 1'b0;
        no_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check("midrst stays idle", 32'(no_done), 32'd1);
        do_op("9/3", 8'd9, 8'd3, 8, 8'd3, 8'd0, 1'b0);

        // Operand sweep against the bench's own integer model.
        vecs[0] = '{8'd13, 8'd13};
        vecs[1] = '{8'd12, 8'd13};
        vecs[2] = '{8'd255, 8'd255};
        vecs[3] = '{8'd254, 8'd255};
        vecs[4] = '{8'd128, 8'd3};
        vecs[5] = '{8'd1, 8'd1};
        vecs[6] = '{8'd0, 8'd5};
        vecs[7] = '{8'd77, 8'd10};
        vecs[8] = '{8'd250, 8'd16};
        vecs[9] = '{8'd99, 8'd98};
        for (int i = 0; i < 16; i++) begin
            if (i < 10) begin
                ra = vecs[i].a;
                rb = vecs[i].b;
            end else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(1, 255));
            end
            do_op($sformatf("sweep %0d/%0d", ra, rb), ra, rb, 8, ra / rb, ra % rb, 1'b0);
            check($sformatf("sweep %0d/%0d identity", ra, rb),
                  32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            check($sformatf("sweep %0d/%0d rem_lt_div", ra, rb),
                  32'(remainder < rb), 32'd1);
        end
        go_idle("sweep end", quotient, remainder);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_restoring_divider

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/quotient width in bits (legal 4..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-009 SHALL have port quotient  output  WIDTH  unsigned quotient, held until next accepted start.
REQ-010 SHALL have port remainder  output  WIDTH  unsigned remainder, held until next accepted start.
REQ-011 SHALL have port div_by_zero  output  1  high with result when captured divisor was 0, held with result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE/DONE + start=1 SHALL capture operands, clear partial remainder (WIDTH+1 bits) and bit counter, enter RUN; start=0 in DONE SHALL return to IDLE.
REQ-014 start while in RUN SHALL be ignored with no effect on the operation in progress.
REQ-015 Each RUN cycle SHALL shift {partial remainder, dividend} left one bit, compute trial = partial - {0,divisor} with the subtractor sub-module, and keep trial and set quotient LSB to 1 when no borrow, else restore and set quotient LSB to 0.
REQ-016 RUN SHALL last exactly WIDTH cycles (counter 0..WIDTH-1, no wrap), then enter DONE.
REQ-017 done SHALL be 1 for exactly the one cycle spent in DONE; start accepted at edge k gives done=1 in cycle k+WIDTH+1.
REQ-018 quotient/remainder/div_by_zero SHALL update only on entering DONE and be stable otherwise; remainder < divisor always when divisor != 0.
REQ-019 Divisor = 0 SHALL skip RUN: enter DONE on next edge with quotient = all ones, remainder = dividend, div_by_zero = 1 (done at k+1).
REQ-020 Back-to-back: start=1 during DONE SHALL be accepted, so a new operation begins without an IDLE cycle.
REQ-021 Arithmetic SHALL be unsigned; no overflow is possible for divisor != 0.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter and partial remainder 0.
REQ-023 rst mid-RUN SHALL abandon the operation without asserting done; rst SHALL take priority over simultaneous start.

Structure
REQ-024 FSM state encoding and the default WIDTH constant SHALL live in the shared arithmetic package.
REQ-025 The subtractor SHALL be one sub-module cla_subtractor (parameter WIDTH+1), computing a + ~b + 1 with generate/propagate carry-lookahead and outputting difference and borrow (= NOT carry-out); it is the sole combinational datapath.

Verification (WIDTH=8)
REQ-026 start with 200/7 -> busy for 8 cycles, done at k+9, quotient=28, remainder=4, div_by_zero=0.
REQ-027 start with 255/1 -> quotient=255, remainder=0; then 5/9 back-to-back via start in DONE -> quotient=0, remainder=5.
REQ-028 start with 100/0 -> done at k+1, quotient=255, remainder=100, div_by_zero=1, busy never high.
REQ-029 start with 200/7, then start with 10/2 pulsed at cycle k+3 -> ignored; result 28 r 4.
REQ-030 rst asserted at cycle k+4 of 200/7 -> no done pulse, all outputs 0, IDLE next cycle; new 9/3 -> quotient=3, remainder=0.
REQ-031 Random unsigned operand sweep (divisor != 0) -> quotient*divisor + remainder == dividend and remainder < divisor for every result.
